// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage at the front of the cpu_top pipeline.
//
// Owns the fetch PC, issues word-aligned requests to a synchronous-read
// instruction SRAM, holds the returned word across decode stalls and presents
// {pc, inst} to the ID stage under a valid/allow-in handshake. A branch
// redirect from ID cancels the instruction currently held in this stage and
// fetches the target in the same cycle (no delay slot).
//
// Parameters
//   RESET_PC          address of the first fetch after reset (word-aligned)
//
// Ports
//   clk               system clock, rising-edge active
//   reset             synchronous active-high reset
//   inst_sram_en      fetch request strobe
//   inst_sram_addr    fetch address (combinational next PC)
//   inst_sram_rdata   SRAM read data, valid one cycle after the request
//   ds_allowin        ID stage can accept an instruction this cycle
//   br_taken          redirect request from ID (one cycle per branch)
//   br_target         redirect address, bits [1:0] ignored
//   fs_to_ds_valid    instruction presented to ID
//   fs_to_ds_pc       PC of the presented instruction
//   fs_to_ds_inst     presented instruction word
//   fs_fetch_cnt      count of instructions handed to ID (only when the
//                     IF_PERF_CNT_EN macro is defined)
//
// Build option
//   IF_PERF_CNT_EN    adds the fs_fetch_cnt port and its 32-bit counter.
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_to_ds_pc,
  output logic [31:0] fs_to_ds_inst
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fs_fetch_cnt
`endif
);

  // fs_pc resets one word below RESET_PC so that the ordinary sequential
  // increment produces RESET_PC as the first request.
  localparam logic [31:0] RESET_FS_PC = RESET_PC - 32'd4;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic        fs_valid_q,       fs_valid_d;
  logic [31:0] fs_pc_q,          fs_pc_d;
  logic        inst_buf_valid_q, inst_buf_valid_d;
  logic [31:0] inst_buf_q,       inst_buf_d;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic        fs_allowin;
  logic        br_redirect;
  logic        handover;
  logic [31:0] br_target_aligned;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;

  // The low two target bits carry no meaning for a word-addressed fetch.
  logic br_target_unused;
  assign br_target_unused = ^br_target[1:0];

  assign br_target_aligned = {br_target[31:2], 2'b00};

  // Sequential successor; wraps modulo 2^32 naturally.
  assign seq_pc = fs_pc_q + 32'd4;

  // A redirect is only honoured once the stage has fetched something since
  // reset. fs_valid_q is low only between reset and the first fetch, so this
  // guarantees that the first request after reset is always RESET_PC even if
  // br_taken happens to be high on that cycle.
  assign br_redirect = br_taken & fs_valid_q & ~reset;

  assign nextpc = br_redirect ? br_target_aligned : seq_pc;

  // The stage is always ready to go, so it can accept a new fetch whenever
  // it is empty or its current instruction is leaving this cycle.
  assign fs_allowin = ~fs_valid_q | ds_allowin;

  // A redirect always issues, even while ID is stalled: the stale
  // instruction is being thrown away, so there is nothing to hold.
  assign inst_sram_en   = ~reset & (fs_allowin | br_taken);
  assign inst_sram_addr = nextpc;

  // ---------------------------------------------------------------------------
  // Outputs to ID
  // ---------------------------------------------------------------------------
  // The instruction is suppressed in the cycle a branch resolves so the
  // wrong-path word is never accepted by ID.
  assign fs_to_ds_valid = fs_valid_q & ~br_taken;
  assign fs_to_ds_pc    = fs_pc_q;

  // SRAM data is only valid for the single cycle after the request; from the
  // first stall edge onward the buffered copy is presented instead.
  assign fs_to_ds_inst  = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;

  assign handover = fs_to_ds_valid & ds_allowin;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    fs_valid_d       = fs_valid_q;
    fs_pc_d          = fs_pc_q;
    inst_buf_valid_d = inst_buf_valid_q;
    inst_buf_d       = inst_buf_q;

    if (inst_sram_en) begin
      // New fetch in flight: its data arrives on the SRAM port next cycle,
      // so any buffered copy of the previous instruction is obsolete.
      fs_valid_d       = 1'b1;
      fs_pc_d          = nextpc;
      inst_buf_valid_d = 1'b0;
    end else if (fs_valid_q && !inst_buf_valid_q) begin
      // First stall edge: the SRAM word for fs_pc is on the read port right
      // now and will not be there next cycle, so capture it. Later stall
      // edges leave the buffer untouched.
      inst_buf_valid_d = 1'b1;
      inst_buf_d       = inst_sram_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_FS_PC;
      inst_buf_valid_q <= 1'b0;
      inst_buf_q       <= 32'h0000_0000;
    end else begin
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      inst_buf_valid_q <= inst_buf_valid_d;
      inst_buf_q       <= inst_buf_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Retired-fetch counter: counts handovers to ID only, so instructions
  // cancelled by a redirect or by reset are never included.
  // ---------------------------------------------------------------------------
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (handover) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= 32'h0000_0000;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign fs_fetch_cnt = fetch_cnt_q;
`else
  // Without the counter the handover strobe has no consumer.
  logic handover_unused;
  assign handover_unused = handover;
`endif

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// A synchronous SRAM model returns (address ^ salt) one cycle after each
// request and random garbage on idle cycles, so a stage that fails to hold
// the instruction across a stall presents a wrong word. The reference model
// describes the stage as "which instruction (if any) ID currently sees" and
// derives every expected output from that plus the fetch rules.
// -----------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset      = 1'b1;
  logic        ds_allowin = 1'b0;
  logic        br_taken   = 1'b0;
  logic [31:0] br_target  = 32'h0;
  logic [31:0] rdata      = 32'h0;
  logic [31:0] rdata2     = 32'h0;
  logic [31:0] salt       = 32'h0;

  logic        en, en2;
  logic [31:0] addr, addr2;
  logic        valid, valid2;
  logic [31:0] pc, pc2, inst, inst2;
`ifdef IF_PERF_CNT_EN
  logic [31:0] cnt, cnt2;
`endif

  int checks   = 0;
  int failures = 0;

  if_stage #(.RESET_PC(RPC)) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (en),
    .inst_sram_addr  (addr),
    .inst_sram_rdata (rdata),
    .ds_allowin      (ds_allowin),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .fs_to_ds_valid  (valid),
    .fs_to_ds_pc     (pc),
    .fs_to_ds_inst   (inst)
`ifdef IF_PERF_CNT_EN
    ,
    .fs_fetch_cnt    (cnt)
`endif
  );

  if_stage #(.RESET_PC(RPC2)) dut_wrap (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (en2),
    .inst_sram_addr  (addr2),
    .inst_sram_rdata (rdata2),
    .ds_allowin      (ds_allowin),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .fs_to_ds_valid  (valid2),
    .fs_to_ds_pc     (pc2),
    .fs_to_ds_inst   (inst2)
`ifdef IF_PERF_CNT_EN
    ,
    .fs_fetch_cnt    (cnt2)
`endif
  );

  // Synchronous-read SRAM: data for a request appears one cycle later; idle
  // cycles scramble the read port.
  always @(posedge clk) begin
    rdata  <= en  ? (addr  ^ salt) : $urandom;
    rdata2 <= en2 ? (addr2 ^ salt) : $urandom;
  end

  // Reference model: what ID sees and how many instructions it has taken.
  bit          m_valid  = 1'b0;
  logic [31:0] m_pc     = RPC - 32'd4;
  logic [31:0] m_cnt    = 32'h0;
  bit          prev_rst = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, then
  // advance the model across the coming edge.
  task automatic step(input bit rst, input bit alw, input bit br, input logic [31:0] tgt);
    bit          e_en;
    bit          e_valid;
    bit          hand;
    logic [31:0] e_addr;
    @(posedge clk);
    #1;
    reset      = rst;
    ds_allowin = alw;
    br_taken   = br;
    br_target  = tgt;
    #1;
    e_en    = !rst && (!m_valid || alw || br);
    e_valid = m_valid && !br;
    if (m_valid && br)
      e_addr = tgt & 32'hFFFF_FFFC;
    else if (m_valid)
      e_addr = m_pc + 32'd4;
    else
      e_addr = RPC;

    chk("sram_en", {31'b0, en}, {31'b0, e_en});
    // Outputs are defined once the stage is out of reset or has seen a reset edge.
    if (!rst || prev_rst) begin
      chk("sram_addr", addr, e_addr);
      chk("ds_valid", {31'b0, valid}, {31'b0, e_valid});
      chk("ds_pc", pc, m_pc);
      if (e_valid)
        chk("ds_inst", inst, m_pc ^ salt);
`ifdef IF_PERF_CNT_EN
      chk("fetch_cnt", cnt, m_cnt);
`endif
    end
    $display("cyc rst=%0d alw=%0d br=%0d tgt=%h | en=%0d addr=%h valid=%0d pc=%h inst=%h",
             rst, alw, br, tgt, en, addr, valid, pc, inst);

    hand = !rst && e_valid && alw;
    if (rst) begin
      m_valid = 1'b0;
      m_pc    = RPC - 32'd4;
      m_cnt   = 32'h0;
    end else begin
      if (hand) m_cnt = m_cnt + 32'd1;
      if (e_en) begin
        m_valid = 1'b1;
        m_pc    = e_addr;
      end
    end
    prev_rst = rst;
  endtask

  initial begin
    // Reset, with a spurious branch pending that must be ignored.
    step(1, 1, 0, 32'h0);
    step(1, 1, 1, 32'h0000_0055);
    chk("wrap_rst_valid", {31'b0, valid2}, 32'h0);
    chk("wrap_rst_pc", pc2, RPC2 - 32'd4);
    chk("wrap_rst_addr", addr2, RPC2);

    // Release: sequential fetch 0,4,8 with word = address.
    step(0, 1, 0, 32'h0);                 // C0: request 0
    chk("wrap_req0", addr2, RPC2);
    step(0, 1, 0, 32'h0);                 // C1: present 0, request 4
    chk("wrap_req1", addr2, 32'h0000_0000);
    step(0, 1, 0, 32'h0);                 // present 4

    // Stall 3 cycles with pc=8 presented; SRAM port scrambles meanwhile.
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    step(0, 1, 0, 32'h0);                 // release, request 12
    chk("after_stall_req", addr, 32'h0000_000C);
    step(0, 1, 0, 32'h0);                 // present 12

    // Branch while 0x10 is presented.
    step(0, 1, 1, 32'h0000_0103);
    chk("br_addr", addr, 32'h0000_0100);
    step(0, 1, 0, 32'h0);                 // present 0x100
    chk("br_target_pc", pc, 32'h0000_0100);

    // Branch to 0x20, stall with it buffered, then redirect to 0x40.
    step(0, 1, 1, 32'h0000_0020);
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    step(0, 0, 1, 32'h0000_0040);
    chk("stall_br_addr", addr, 32'h0000_0040);
    step(0, 1, 0, 32'h0);                 // present 0x40
    step(0, 1, 0, 32'h0);

    // One-cycle reset mid-stream.
    step(1, 1, 1, 32'h0000_0300);
    step(0, 1, 1, 32'h0000_0300);         // first request after reset
    chk("post_rst_addr", addr, RPC);
    step(0, 1, 0, 32'h0);

    // Five handovers and one cancelled instruction.
    step(1, 1, 0, 32'h0);
    step(0, 1, 0, 32'h0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 32'h0);
    step(0, 1, 1, 32'h0000_0200);
    step(0, 0, 0, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt_5", cnt, 32'd5);
`endif

    // Randomised traffic with a fresh memory pattern.
    step(1, 1, 0, 32'h0);
    salt = $urandom;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 2),
           $urandom);
    end

    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage at the front of the `cpu_top` pipeline. It owns the PC and issues requests to the synchronous-read instruction SRAM. It buffers the returned instruction across decode stalls and hands {pc, inst} to the ID stage under a valid/allow-in handshake. Branch redirects from ID cancel the in-flight fetch and restart fetching at the target.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: address of the first fetch after reset; must be word-aligned.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inst_sram_en`  out  1  fetch request strobe.
- `inst_sram_addr`  out  32  fetch address, word-aligned.
- `inst_sram_rdata`  in  32  SRAM read data; valid exactly one cycle after the request.
- `ds_allowin`  in  1  ID stage can accept an instruction this cycle.
- `br_taken`  in  1  redirect request from ID; held for one cycle per branch.
- `br_target`  in  32  redirect address; bits [1:0] are ignored.
- `fs_to_ds_valid`  out  1  instruction presented to ID.
- `fs_to_ds_pc`  out  32  PC of the presented instruction.
- `fs_to_ds_inst`  out  32  presented instruction word.
- `fs_fetch_cnt`  out  32  retired-fetch counter. This port exists only with `IF_PERF_CNT_EN`.

## Operation
- State:
  - `fs_valid` (reset 0)
  - `fs_pc` (reset `RESET_PC`-4)
  - `inst_buf_valid` (reset 0)
  - `inst_buf` (reset 0)
- `fs_allowin = !fs_valid | ds_allowin`. The stage is always ready to go.
- `nextpc = br_taken ? {br_target[31:2],2'b00} : fs_pc + 4`. Addition is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- `inst_sram_en = !reset & (fs_allowin | br_taken)`. `inst_sram_addr = nextpc` (combinational).
- On an edge where `inst_sram_en`=1: `fs_pc <= nextpc`, `fs_valid <= 1`, `inst_buf_valid <= 0`.
- On an edge where `inst_sram_en`=0 and `fs_valid`=1:
  - If `inst_buf_valid`=0, capture `inst_buf <= inst_sram_rdata` and set `inst_buf_valid <= 1`.
  - The buffer then holds until the instruction leaves or is cancelled.
- `fs_to_ds_inst = inst_buf_valid ? inst_buf : inst_sram_rdata`.
- `fs_to_ds_pc = fs_pc`.
- `fs_to_ds_valid = fs_valid & !br_taken`.
- Handover: the instruction transfers to ID on an edge where `fs_to_ds_valid & ds_allowin`.
- Branch handling:
  - `br_taken`=1 discards the current FS instruction, whether or not it is stalled or buffered.
  - Fetch of `br_target` issues in the same cycle.
  - No delay slot.
- Simultaneous `br_taken` and `ds_allowin`=0: the redirect wins. The target is fetched and the stale instruction is never presented.
- Reset mid-operation:
  - All state returns to reset values on the next edge.
  - `inst_sram_en`=0 while `reset`=1.
  - The first fetch after reset is always `RESET_PC`, regardless of any pending branch.

## Timing
- Reset value of every output while `reset`=1, after the first edge:
  - `inst_sram_en`=0, `inst_sram_addr`=`RESET_PC`.
  - `fs_to_ds_valid`=0, `fs_to_ds_pc`=`RESET_PC`-4.
  - `fs_to_ds_inst`=`inst_sram_rdata` (ignored while invalid).
  - `fs_fetch_cnt`=0.
- Cycle C0 (first cycle with `reset`=0): request `RESET_PC`.
- Cycle C1: `fs_to_ds_valid`=1 with `pc`=`RESET_PC`.
- Fetch-to-present latency is 1 cycle.
- Throughput: 1 instruction per cycle while `ds_allowin`=1.
- Stall: the presented pc and inst stay stable for every cycle `ds_allowin`=0. The buffer captures the SRAM data on the first stall edge, so `inst_sram_rdata` may change afterwards.
- Redirect: `br_taken` at cycle N puts `br_target` on `inst_sram_addr` in cycle N. The target instruction is presented at N+1.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - Adds the 32-bit `fs_fetch_cnt` port and register.
  - Reset value 0; increments by 1 on every handover edge and wraps at 2^32.
  - Cancelled instructions are not counted.
- `IF_PERF_CNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset release with `RESET_PC`=0, `ds_allowin`=1, SRAM returning word = address:
  - Requests are 0, 4, 8, ... in consecutive cycles.
  - ID sees pc/inst 0/0, 4/4, 8/8 starting one cycle after the first request.
- Stall: drop `ds_allowin` for 3 cycles while pc=8 is presented, and corrupt `inst_sram_rdata` during the stall.
  - `inst_sram_en`=0 for those cycles.
  - Output holds 8/8.
  - Next request is 12 after release.
- Branch: `br_taken`=1 with `br_target`=32'h0000_0103 while pc=0x10 is presented.
  - `fs_to_ds_valid`=0 that cycle, and `inst_sram_addr`=0x100.
  - Next cycle presents pc 0x100.
  - pc 0x14 is never presented.
- Branch during stall: `ds_allowin`=0 with pc=0x20 buffered, then `br_taken` to 0x40.
  - Fetch of 0x40 issues immediately.
  - 0x20 is never handed over.
- Wrap and reset mid-operation:
  - With `RESET_PC`=32'hFFFF_FFFC, the second request is 0.
  - Asserting `reset` for 1 cycle mid-stream makes the next request after reset `RESET_PC`, with `fs_to_ds_valid`=0 during reset.
- With `IF_PERF_CNT_EN`: 5 handovers plus 1 cancelled instruction gives `fs_fetch_cnt`=5.
